// File: rtl/imem_loader.sv
// imem_loader -- byte-stream program loader feeding instruction memory.
//
// Accepts a framed program (count byte N, 4N big-endian data bytes, XOR
// checksum byte) over a valid/ready byte interface. Each assembled word is
// written to instruction memory at byte address word_index*4. The CPU is
// held in reset until a frame completes with a matching checksum.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   start_i               begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid_i/data_i   stream byte from the source
//   byte_ready_o          loader accepts a byte this cycle
//   imem_we_o/addr_o/data_o  one-cycle word write to instruction memory
//   cpu_rst_o             CPU reset, low only in DONE
//   done_o / err_o        load finished good / aborted
module imem_loader #(
   parameter int DEPTH = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_data_o,
   output logic        cpu_rst_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t      state_q, state_d;
   logic [7:0]  n_q, n_d;
   logic [7:0]  widx_q, widx_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [7:0]  xor_q, xor_d;
   logic [31:0] word_q, word_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic xfer;
   // ready is registered alongside the state, so it already reflects
   // whether the current state can consume a byte.
   assign xfer = byte_valid_i & ready_q;

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      xor_d     = xor_q;
      word_d    = word_q;
      ready_d   = ready_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      cpu_rst_d = cpu_rst_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_COUNT;
               ready_d = 1'b1;
            end
         end
         S_COUNT: begin
            if (xfer) begin
               xor_d = byte_data_i;
               if (byte_data_i == 8'd0 || byte_data_i > DEPTH_B) begin
                  state_d = S_ERROR;
                  ready_d = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  n_d     = byte_data_i;
                  widx_d  = 8'd0;
                  bidx_d  = 2'd0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d = {word_q[23:0], byte_data_i};
               xor_d  = xor_q ^ byte_data_i;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  // Strobe is launched here so it is high exactly during WRITE.
                  state_d = S_WRITE;
                  ready_d = 1'b0;
                  we_d    = 1'b1;
                  addr_d  = {22'd0, widx_q, 2'b00};
                  data_d  = {word_q[23:0], byte_data_i};
               end
            end
         end
         S_WRITE: begin
            ready_d = 1'b1;
            if (widx_q == 8'(n_q - 8'd1)) begin
               state_d = S_CHECK;
            end else begin
               widx_d  = widx_q + 8'd1;
               bidx_d  = 2'd0;
               state_d = S_DATA;
            end
         end
         S_CHECK: begin
            if (xfer) begin
               ready_d = 1'b0;
               if (byte_data_i == xor_q) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (start_i) begin
               state_d   = S_COUNT;
               ready_d   = 1'b1;
               done_d    = 1'b0;
               cpu_rst_d = 1'b1;
            end
         end
         S_ERROR: begin
            if (start_i) begin
               state_d = S_COUNT;
               ready_d = 1'b1;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            ready_d   = 1'b0;
            cpu_rst_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         n_q       <= 8'd0;
         widx_q    <= 8'd0;
         bidx_q    <= 2'd0;
         xor_q     <= 8'd0;
         word_q    <= 32'd0;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'd0;
         data_q    <= 32'd0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         widx_q    <= widx_d;
         bidx_q    <= bidx_d;
         xor_q     <= xor_d;
         word_q    <= word_d;
         ready_q   <= ready_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_data_o  = data_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_imem_loader;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        imem_we_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_o;
   logic        cpu_rst_o;
   logic        done_o;
   logic        err_o;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
      .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o),
      .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // Write monitor: records every memory write, and the loader must never
   // offer ready while a word is being written.
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   always @(negedge clk) begin
      if (imem_we_o) begin
         wa.push_back(imem_addr_o);
         wd.push_back(imem_data_o);
         chk("ready_during_write", {31'd0, byte_ready_o}, 32'd0);
      end
   end

   // Send one byte; caller is aligned just after a negedge.
   task automatic send(input logic [7:0] b);
      int  n = 0;
      bit  acc = 1'b0;
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      while (!acc && n < 50) begin
         acc = byte_ready_o;
         @(negedge clk);
         n++;
      end
      byte_valid_i = 1'b0;
      byte_data_i  = $urandom();
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte 0x%0h never accepted", b);
      end
   endtask

   // Frame builder: count, words base+k (or random), checksum ^ csx.
   // An illegal count produces only the count byte, as nothing follows it.
   logic [7:0] stm[$];
   task automatic build(input int n, input logic [31:0] base, input bit rnd, input logic [7:0] csx);
      logic [7:0]  x;
      logic [31:0] w;
      stm.delete();
      stm.push_back(8'(n));
      if (n >= 1 && n <= DEPTH) begin
         x = 8'(n);
         for (int k = 0; k < n; k++) begin
            w = rnd ? $urandom() : base + 32'(k);
            for (int j = 3; j >= 0; j--) begin
               stm.push_back(w[8*j +: 8]);
               x ^= w[8*j +: 8];
            end
         end
         stm.push_back(x ^ csx);
      end
   endtask

   // Start a load, stream the frame, then check writes and outcome against
   // a model computed directly from the frame rules.
   task automatic run_load(input string tag, input bit gaps);
      logic [31:0] ea[$];
      logic [31:0] ed[$];
      logic [7:0]  x;
      bit          edone;
      int          n;
      n = int'(stm[0]);
      edone = 1'b0;
      if (n >= 1 && n <= DEPTH) begin
         x = 8'd0;
         for (int i = 0; i <= 4*n; i++) x ^= stm[i];
         for (int k = 0; k < n; k++) begin
            ea.push_back(32'(k * 4));
            ed.push_back({stm[1+4*k], stm[2+4*k], stm[3+4*k], stm[4+4*k]});
         end
         edone = (x == stm[4*n+1]);
      end
      wa.delete();
      wd.delete();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      foreach (stm[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         send(stm[i]);
      end
      repeat (2) @(negedge clk);
      chk({tag, "_nwe"}, 32'(wa.size()), 32'(ea.size()));
      foreach (ea[i]) begin
         if (i < wa.size()) begin
            chk({tag, "_addr"}, wa[i], ea[i]);
            chk({tag, "_data"}, wd[i], ed[i]);
         end
      end
      chk({tag, "_done"}, {31'd0, done_o}, {31'd0, edone});
      chk({tag, "_err"}, {31'd0, err_o}, {31'd0, !edone});
      chk({tag, "_cpu_rst"}, {31'd0, cpu_rst_o}, {31'd0, !edone});
      chk({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
   endtask

   task automatic load_case1(input logic [7:0] cs);
      stm = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, cs};
   endtask

   typedef struct {
      int          n;
      logic [31:0] base;
      logic [7:0]  csx;
      bit          exp_done;
      bit          exp_err;
      int          exp_nwe;
      logic [31:0] last_addr;
      logic [31:0] last_data;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{0,   32'h0,         8'h00, 1'b0, 1'b1, 0,  32'h0,  32'h0};
      tbl[1] = '{33,  32'h0,         8'h00, 1'b0, 1'b1, 0,  32'h0,  32'h0};
      tbl[2] = '{32,  32'h1000_0000, 8'h00, 1'b1, 1'b0, 32, 32'h7C, 32'h1000_001F};
      tbl[3] = '{1,   32'hDEAD_BEEF, 8'h01, 1'b0, 1'b1, 1,  32'h0,  32'hDEAD_BEEF};
      tbl[4] = '{255, 32'h0,         8'h00, 1'b0, 1'b1, 0,  32'h0,  32'h0};

      rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      chk("rst_we", {31'd0, imem_we_o}, 32'd0);
      chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
      chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
      chk("rst_addr_data", imem_addr_o | imem_data_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'd0, byte_ready_o}, 32'd0);

      // Two-word load, then bad checksum, then recovery from ERROR.
      load_case1(8'h0C); run_load("case1", 1'b0);
      chk("case1_w0", wd.size() > 0 ? wd[0] : 32'hx, 32'h2008_0005);
      chk("case1_w1", wd.size() > 1 ? wd[1] : 32'hx, 32'h2009_000A);
      load_case1(8'h0D); run_load("badcs", 1'b0);
      load_case1(8'h0C); run_load("recover", 1'b0);

      // Backpressure / gaps on the case-1 stream.
      for (int r = 0; r < 3; r++) begin
         load_case1(8'h0C); run_load("gaps", 1'b1);
      end

      // Table-driven frames.
      for (int i = 0; i < 5; i++) begin
         build(tbl[i].n, tbl[i].base, 1'b0, tbl[i].csx);
         run_load($sformatf("tbl%0d", i), 1'b0);
         chk($sformatf("tbl%0d_nwe", i), 32'(wa.size()), 32'(tbl[i].exp_nwe));
         chk($sformatf("tbl%0d_flags", i), {30'd0, done_o, err_o},
             {30'd0, tbl[i].exp_done, tbl[i].exp_err});
         if (tbl[i].exp_nwe > 0 && wa.size() > 0) begin
            chk($sformatf("tbl%0d_last_addr", i), wa[wa.size()-1], tbl[i].last_addr);
            chk($sformatf("tbl%0d_last_data", i), wd[wd.size()-1], tbl[i].last_data);
         end
      end

      // start_i mid-frame is ignored: pulse it between data bytes.
      load_case1(8'h0C);
      wa.delete(); wd.delete();
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
      foreach (stm[i]) begin
         if (i == 3) begin start_i = 1'b1; @(negedge clk); start_i = 1'b0; end
         send(stm[i]);
      end
      repeat (2) @(negedge clk);
      chk("midstart_nwe", 32'(wa.size()), 32'd2);
      chk("midstart_done", {31'd0, done_o}, 32'd1);

      // Asynchronous reset after 5 accepted bytes.
      load_case1(8'h0C);
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
      for (int i = 0; i < 5; i++) send(stm[i]);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
      chk("arst_we", {31'd0, imem_we_o}, 32'd0);
      chk("arst_ready", {31'd0, byte_ready_o}, 32'd0);
      chk("arst_done_err", {30'd0, done_o, err_o}, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      run_load("after_rst", 1'b1);

      // Randomized frames, including illegal counts and bad checksums.
      for (int r = 0; r < 12; r++) begin
         int n;
         n = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, 255) : $urandom_range(1, 6);
         build(n, 32'h0, 1'b1, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
         run_load("rand", r[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; the write-side counterpart of the CPU's instruction fetch path.
- Receives a framed program over a valid/ready byte interface and assembles bytes into 32-bit instructions.
- Writes each instruction into instruction memory at word-aligned byte addresses, using the same address space as the program counter.
- Holds the CPU in reset until a load completes with a correct checksum.

Parameters:
- DEPTH, 32: instruction memory depth in words; legal range 1..255.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a new load; sampled only in IDLE, DONE or ERROR.
- byte_valid_i  in  1  source has a byte on byte_data_i.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts the byte this cycle. A transfer occurs when valid and ready are both 1.
- imem_we_o  out  1  instruction memory write strobe, one cycle per word.
- imem_addr_o  out  32  byte address of the write; word-aligned, low 2 bits always 0.
- imem_data_o  out  32  instruction word to write.
- cpu_rst_o  out  1  active-high reset to the CPU; 1 except in DONE.
- done_o  out  1  load finished with good checksum.
- err_o  out  1  load aborted (bad count or checksum).

Behaviour:
- Frame format:
  - 1 count byte N (1..DEPTH).
  - 4N data bytes, MSB first per word (big-endian).
  - 1 checksum byte = XOR of the count byte and all data bytes.
- Reset (async, any state): state IDLE; all outputs 0 except cpu_rst_o=1; word index, byte index and running XOR cleared.
  - Memory contents already written are not touched.
- IDLE: ready=0. start_i=1 -> COUNT.
- COUNT: ready=1. On transfer:
  - XOR := byte.
  - If byte==0 or byte>DEPTH -> ERROR; else N := byte, word index := 0, byte index := 0 -> DATA.
- DATA: ready=1. On transfer:
  - word register := {word[23:0], byte}; XOR ^= byte; byte index++.
  - On the 4th byte -> WRITE.
- WRITE: ready=0, exactly one cycle.
  - imem_we_o=1, imem_addr_o = word index*4, imem_data_o = assembled word.
  - Then if word index == N-1 -> CHECK; else word index++, byte index := 0 -> DATA.
- CHECK: ready=1. On transfer: byte == XOR -> DONE; otherwise -> ERROR.
- DONE:
  - done_o=1, cpu_rst_o=0, ready=0.
  - start_i=1 -> COUNT, with done_o:=0 and cpu_rst_o:=1 on the same edge.
- ERROR:
  - err_o=1, cpu_rst_o=1, ready=0.
  - start_i=1 -> COUNT, with err_o:=0.
- Output registering and hold:
  - All outputs are registered.
  - imem_addr_o and imem_data_o hold their last values when imem_we_o=0.
- Handshake rules:
  - byte_valid_i with ready=0 is not consumed; the source holds the byte stable.
  - Idle gaps (valid=0) of any length are allowed in COUNT, DATA and CHECK with no state change.
- Timing:
  - A word takes a minimum of 5 cycles: 4 transfers plus the WRITE cycle.
  - Minimum frame time is 1 + 5N + 1 cycles from the first transfer to DONE.
- Error behaviour: words written before a checksum error remain in memory, but the CPU is kept in reset.
- start_i in COUNT, DATA, WRITE or CHECK is ignored.
- Address width: the 32-bit address is formed from the word index zero-extended and shifted left 2; there is no wrap, since N ≤ DEPTH.

Test Plan:
1. Two-word load:
   - Stimulus: start_i pulse, then stream 02,20,08,00,05,20,09,00,0A,0C.
   - Required: write (addr 0x00, data 0x20080005), then write (addr 0x04, data 0x2009000A); done_o=1, cpu_rst_o=0; exactly 2 we pulses.
2. Bad checksum:
   - Stimulus: same stream, but last byte 0D.
   - Required: both writes occur; err_o=1, done_o=0, cpu_rst_o stays 1. A new start_i plus the correct stream then reaches DONE.
3. Illegal count:
   - Stimulus: count byte 00, and separately count byte 21 (33, above DEPTH=32).
   - Required: ERROR on the cycle after the transfer; no imem_we_o pulse; byte_ready_o=0 afterwards.
4. Backpressure and gaps:
   - Stimulus: the case-1 stream with random byte_valid_i deassertion.
   - Required: byte_ready_o=0 during each WRITE cycle; identical writes and final state to case 1; no byte lost or duplicated.
5. Reset mid-load:
   - Stimulus: assert rst_i asynchronously (off the clock edge) after 5 accepted bytes.
   - Required: outputs take reset values immediately (cpu_rst_o=1, we=0, ready=0). A subsequent full load from start_i succeeds.
6. Full-depth load:
   - Stimulus: count 0x20 and 32 words where word k = 0x1000_0000+k, with correct checksum.
   - Required: last write has addr 0x7C and data 0x1000001F; done_o=1; total of 32 we pulses.
